// File: rtl/parking_pkg.sv
// Shared definitions for the parking sensor generator.
// Contents:
//   seq_state_e  per-entry sequencer state
//   DIR_ENTER / DIR_LEAVE  command direction encoding
//   clog2()      constant function that sizes the free-space counter
//   sensor_pat() {a,b} drive pattern for a given state and direction
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH1,
    ST_PH2,
    ST_PH3,
    ST_GAP
  } seq_state_e;

  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_LEAVE = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (((v - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

  // An entering car trips the outer sensor first; a leaving car trips the inner one first.
  function automatic logic [1:0] sensor_pat(input seq_state_e st, input logic dir);
    logic [1:0] ab;
    ab = 2'b00;
    case (st)
      ST_PH1:  ab = (dir == DIR_ENTER) ? 2'b10 : 2'b01;
      ST_PH2:  ab = 2'b11;
      ST_PH3:  ab = (dir == DIR_ENTER) ? 2'b01 : 2'b10;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/parking_sensor_gen_if.sv
// Command / status bundle of the parking sensor generator.
// master: command source (drives cmd_*, observes status).
// slave : the generator (observes cmd_*, drives cmd_ready, a, b, busy,
//         done, cmd_err, free).
// Bit i of a/b/busy/done belongs to entry i.
interface parking_sensor_gen_if #(
  parameter int hold_w = 4,
  parameter int free_w = 7
);
  logic              cmd_valid;
  logic              cmd_entry;
  logic              cmd_dir;
  logic [hold_w-1:0] cmd_hold;
  logic              cmd_ready;
  logic [1:0]        a;
  logic [1:0]        b;
  logic [1:0]        busy;
  logic [1:0]        done;
  logic              cmd_err;
  logic [free_w-1:0] free;

  modport master (
    output cmd_valid, cmd_entry, cmd_dir, cmd_hold,
    input  cmd_ready, a, b, busy, done, cmd_err, free
  );

  modport slave (
    input  cmd_valid, cmd_entry, cmd_dir, cmd_hold,
    output cmd_ready, a, b, busy, done, cmd_err, free
  );
endinterface

// File: rtl/parking_sensor_seq.sv
// One entry's sensor sequencer: IDLE -> PH1 -> PH2 -> PH3 -> GAP -> IDLE.
// Each phase lasts hold+1 cycles (hold latched at start); GAP lasts one
// cycle and pulses done. Outputs are registered and computed from the
// next state so they change on the same edge as the state.
// Ports: clk, rst (async active-low), start (accepted command), dir, hold,
//        idle (combinational), a, b, busy, done.
module parking_sensor_seq
  import parking_pkg::*;
#(
  parameter int hold_w = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [hold_w-1:0] hold,
  output logic              idle,
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic              done
);

  seq_state_e        state_q, state_d;
  logic [hold_w-1:0] cnt_q, cnt_d;
  logic [hold_w-1:0] hold_q, hold_d;
  logic              dir_q, dir_d;
  logic [1:0]        ab_q, ab_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PH1;
          cnt_d   = hold;
          hold_d  = hold;
          dir_d   = dir;
        end
      end
      ST_PH1, ST_PH2, ST_PH3: begin
        if (cnt_q == '0) begin
          cnt_d = hold_q;
          case (state_q)
            ST_PH1:  state_d = ST_PH2;
            ST_PH2:  state_d = ST_PH3;
            default: state_d = ST_GAP;
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ab_d   = sensor_pat(state_d, dir_d);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_GAP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      dir_q   <= DIR_ENTER;
      ab_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      dir_q   <= dir_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign idle = (state_q == ST_IDLE);
  assign a    = ab_q[1];
  assign b    = ab_q[0];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/parking_sensor_gen.sv
// Parking sensor pattern generator with two independent entries.
// Accepts one command per cycle, checks it against the free-space count,
// and starts the selected entry's sensor sequencer when it is admissible.
// Ports: clk, rst (async active-low), bus (parking_sensor_gen_if.slave):
//   cmd_valid/cmd_entry/cmd_dir/cmd_hold in; cmd_ready (combinational),
//   a, b, busy, done, cmd_err, free out.
module parking_sensor_gen
  import parking_pkg::*;
#(
  parameter int capacity = 99,
  parameter int hold_w   = 4
) (
  input logic                 clk,
  input logic                 rst,
  parking_sensor_gen_if.slave bus
);

  localparam int              FREE_W = clog2(capacity);
  localparam logic [FREE_W-1:0] CAP  = FREE_W'(capacity);

  logic [1:0]        idle;
  logic [1:0]        start;
  logic [1:0]        a_w, b_w, busy_w, done_w;
  logic              hs;
  logic              reject;
  logic [FREE_W-1:0] free_q, free_d;
  logic              cmd_err_q, cmd_err_d;

  assign bus.cmd_ready = idle[bus.cmd_entry];
  assign hs            = bus.cmd_valid && bus.cmd_ready;

  // A full lot refuses entries and an empty lot refuses departures; the
  // command is still consumed so the source does not retry it forever.
  assign reject = hs && (((bus.cmd_dir == DIR_ENTER) && (free_q == '0)) ||
                         ((bus.cmd_dir == DIR_LEAVE) && (free_q == CAP)));

  always_comb begin
    start     = 2'b00;
    free_d    = free_q;
    cmd_err_d = reject;
    if (hs && !reject) begin
      start[bus.cmd_entry] = 1'b1;
      if (bus.cmd_dir == DIR_ENTER) free_d = free_q - 1'b1;
      else                          free_d = free_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_q    <= CAP;
      cmd_err_q <= 1'b0;
    end else begin
      free_q    <= free_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_entry
    parking_sensor_seq #(
      .hold_w(hold_w)
    ) u_seq (
      .clk  (clk),
      .rst  (rst),
      .start(start[i]),
      .dir  (bus.cmd_dir),
      .hold (bus.cmd_hold),
      .idle (idle[i]),
      .a    (a_w[i]),
      .b    (b_w[i]),
      .busy (busy_w[i]),
      .done (done_w[i])
    );
  end

  assign bus.a       = a_w;
  assign bus.b       = b_w;
  assign bus.busy    = busy_w;
  assign bus.done    = done_w;
  assign bus.cmd_err = cmd_err_q;
  assign bus.free    = free_q;

endmodule

// File: tb/tb_parking_sensor_gen.sv
module tb_parking_sensor_gen;
  import parking_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  parking_sensor_gen_if #(.hold_w(4), .free_w(7)) bus ();

  parking_sensor_gen #(
    .capacity(99),
    .hold_w  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {a,b} for cycle k (k=1 is the first cycle after the accepting edge).
  function automatic logic [1:0] exp_ab(input logic dir, input int hold, input int k);
    int ph;
    ph = (k - 1) / (hold + 1);
    if (k < 1) return 2'b00;
    case (ph)
      0:       return dir ? 2'b01 : 2'b10;
      1:       return 2'b11;
      2:       return dir ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic exp_done(input int hold, input int k);
    return (k == 3 * (hold + 1) + 1);
  endfunction

  function automatic logic [1:0] ab_of(input int e);
    return {bus.a[e], bus.b[e]};
  endfunction

  // Called at a negedge; handshake happens on the following posedge.
  task automatic send(input logic e, input logic d, input int h);
    bus.cmd_entry = e;
    bus.cmd_dir   = d;
    bus.cmd_hold  = 4'(h);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input logic e);
    int n;
    n = 0;
    bus.cmd_entry = e;
    #1;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_entry = 1'b0;
    bus.cmd_dir   = DIR_ENTER;
    bus.cmd_hold  = 4'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a", 32'(bus.a), 32'd0);
    chk("rst_b", 32'(bus.b), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.cmd_err), 32'd0);
    chk("rst_free", 32'(bus.free), 32'd99);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    rst = 1'b1;

    // Enter on entry 0, hold=1, accepted on the first edge after release
    send(1'b0, DIR_ENTER, 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("ent0_ab_k%0d", k), 32'(ab_of(0)), 32'(exp_ab(DIR_ENTER, 1, k)));
      chk($sformatf("ent0_done_k%0d", k), 32'(bus.done[0]), 32'(exp_done(1, k)));
      chk($sformatf("ent0_busy_k%0d", k), 32'(bus.busy[0]), 32'd1);
      chk($sformatf("ent0_ab1_k%0d", k), 32'(ab_of(1)), 32'd0);
      if (k == 1) chk("ent0_free", 32'(bus.free), 32'd98);
    end
    @(negedge clk);
    chk("ent0_ready_after", 32'(bus.cmd_ready), 32'd1);
    chk("ent0_busy_after", 32'(bus.busy[0]), 32'd0);
    chk("ent0_done_after", 32'(bus.done[0]), 32'd0);

    // Leave on entry 1, hold=0
    send(1'b1, DIR_LEAVE, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lv1_ab_k%0d", k), 32'(ab_of(1)), 32'(exp_ab(DIR_LEAVE, 0, k)));
      chk($sformatf("lv1_done_k%0d", k), 32'(bus.done[1]), 32'(exp_done(0, k)));
      if (k == 1) chk("lv1_free", 32'(bus.free), 32'd99);
    end
    @(negedge clk);

    // Leave with the lot empty of cars: rejected
    send(1'b0, DIR_LEAVE, 2);
    @(negedge clk);
    chk("lvfull_err", 32'(bus.cmd_err), 32'd1);
    chk("lvfull_ab", 32'(ab_of(0)), 32'd0);
    chk("lvfull_busy", 32'(bus.busy), 32'd0);
    chk("lvfull_free", 32'(bus.free), 32'd99);
    @(negedge clk);
    chk("lvfull_err_clr", 32'(bus.cmd_err), 32'd0);
    chk("lvfull_ab2", 32'(ab_of(0)), 32'd0);

    // Fill the lot: 99 enters
    for (int i = 0; i < 99; i++) begin
      wait_ready(1'(i % 2));
      send(1'(i % 2), DIR_ENTER, 0);
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("fill_free", 32'(bus.free), 32'd0);
    chk("fill_err", 32'(bus.cmd_err), 32'd0);
    send(1'b0, DIR_ENTER, 0);
    @(negedge clk);
    chk("full_err", 32'(bus.cmd_err), 32'd1);
    chk("full_free", 32'(bus.free), 32'd0);
    chk("full_busy", 32'(bus.busy[0]), 32'd0);
    send(1'b0, DIR_LEAVE, 0);
    @(negedge clk);
    chk("full_lv_free", 32'(bus.free), 32'd1);
    chk("full_lv_err", 32'(bus.cmd_err), 32'd0);
    chk("full_lv_ab", 32'(ab_of(0)), 32'd1);
    repeat (5) @(negedge clk);

    // Bring free to 2, then overlapping enters on both entries
    send(1'b1, DIR_LEAVE, 0);
    repeat (5) @(negedge clk);
    chk("ovl_free_pre", 32'(bus.free), 32'd2);
    send(1'b0, DIR_ENTER, 1);
    @(negedge clk);
    send(1'b1, DIR_ENTER, 1);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      chk($sformatf("ovl_ab0_j%0d", j), 32'(ab_of(0)), 32'(exp_ab(DIR_ENTER, 1, j + 1)));
      chk($sformatf("ovl_ab1_j%0d", j), 32'(ab_of(1)), 32'(exp_ab(DIR_ENTER, 1, j)));
      chk($sformatf("ovl_done0_j%0d", j), 32'(bus.done[0]), 32'(exp_done(1, j + 1)));
      chk($sformatf("ovl_done1_j%0d", j), 32'(bus.done[1]), 32'(exp_done(1, j)));
      if (j == 1) begin
        chk("ovl_free", 32'(bus.free), 32'd0);
        bus.cmd_entry = 1'b0;
        bus.cmd_dir   = DIR_ENTER;
        bus.cmd_valid = 1'b1;
        #1 chk("ovl_busy_ready", 32'(bus.cmd_ready), 32'd0);
      end
      if (j == 2) begin
        bus.cmd_valid = 1'b0;
        chk("ovl_busy_noerr", 32'(bus.cmd_err), 32'd0);
        chk("ovl_busy_free", 32'(bus.free), 32'd0);
      end
    end
    repeat (2) @(negedge clk);

    // Reset in the middle of PH2
    send(1'b1, DIR_LEAVE, 0);
    repeat (5) @(negedge clk);
    chk("mid_free_pre", 32'(bus.free), 32'd1);
    send(1'b0, DIR_ENTER, 3);
    repeat (5) @(negedge clk);
    chk("mid_ph2_ab", 32'(ab_of(0)), 32'd3);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_ab", 32'(ab_of(0)), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_free", 32'(bus.free), 32'd99);
    @(posedge clk);
    #1 chk("mid_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send(1'b0, DIR_ENTER, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_ab_k%0d", k), 32'(ab_of(0)), 32'(exp_ab(DIR_ENTER, 0, k)));
      chk($sformatf("post_done_k%0d", k), 32'(bus.done[0]), 32'(exp_done(0, k)));
      if (k == 1) chk("post_free", 32'(bus.free), 32'd98);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
